// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM encoding and framing constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
  localparam int DATA_BITS = 8;
  localparam int MIN_CLKS_PER_BIT = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with parameterizable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver emitting each byte as a single-beat stream transfer
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 rx,
  output logic                 m_axis_tvalid,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 frame_error,
  output logic                 busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT || CLKS_PER_BIT % 2 != 0) begin : g_bad_cfg
    $error("CLKS_PER_BIT must be even and >= %0d", MIN_CLKS_PER_BIT);
  end
  logic rx_s;
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n, td_n;
  logic tv_n, fe_n;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(aclk), .rst(areset), .d(rx), .q(rx_s));
  always_ff @(posedge aclk)
    if (areset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      m_axis_tdata <= td_n;
      m_axis_tvalid <= tv_n;
      frame_error <= fe_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    td_n = m_axis_tdata;
    tv_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (cnt == CW'(HALF - 1)) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n = '0;
          sh_n = {rx_s, sh[DATA_BITS-1:1]};
          idx_n = idx + 1'b1;
          state_n = (idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
        end
      STOP:
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n = '0;
          tv_n = rx_s;
          fe_n = !rx_s;
          td_n = rx_s ? sh : m_axis_tdata;
          state_n = rx_s ? IDLE : BREAK;
        end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed self-checking bench for the UART stream receiver
module tb_uart_rx_axis;
  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT = 2 + HALF + 9 * CPB + 1;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic rx = 1'b1;
  logic m_axis_tvalid;
  logic [7:0] m_axis_tdata;
  logic frame_error;
  logic busy;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  int tv_cyc = -1;
  int fe_cyc = -1;
  int t_start = 0;
  logic [7:0] acc = 8'h00;
  logic [7:0] got_q[$];
  uart_rx_axis #(.CLKS_PER_BIT(CPB)) dut (
    .aclk(aclk),
    .areset(areset),
    .rx(rx),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .frame_error(frame_error),
    .busy(busy)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc = cyc + 1;
  always @(negedge aclk) begin
    if (m_axis_tvalid) begin
      tv_cnt = tv_cnt + 1;
      tv_cyc = cyc;
      got_q.push_back(m_axis_tdata);
      acc = acc | m_axis_tdata;
    end
    if (frame_error) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (m_axis_tvalid && frame_error) both_cnt = both_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic clear();
    tv_cnt = 0;
    fe_cnt = 0;
    busy_cnt = 0;
    tv_cyc = -1;
    fe_cyc = -1;
    got_q.delete();
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold);
    t_start = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB + hold);
    rx = 1'b1;
  endtask
  initial begin
    tick(3);
    areset = 1'b0;
    tick(1);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'h00);
    tick(5);
    clear();
    send_frame(8'hA5, 1'b1, 0);
    tick(20);
    check("a5_count", 32'(tv_cnt), 32'd1);
    check("a5_data", 32'(got_q[0]), 32'hA5);
    check("a5_latency", 32'(tv_cyc - t_start), 32'(LAT));
    check("a5_ferr", 32'(fe_cnt), 32'd0);
    check("a5_idle", 32'(busy), 32'd0);
    clear();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    tick(20);
    check("b2b_count", 32'(tv_cnt), 32'd3);
    check("b2b_0", 32'(got_q[0]), 32'h00);
    check("b2b_1", 32'(got_q[1]), 32'hFF);
    check("b2b_2", 32'(got_q[2]), 32'h3C);
    check("b2b_ferr", 32'(fe_cnt), 32'd0);
    clear();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("glitch_tvalid", 32'(tv_cnt), 32'd0);
    check("glitch_busy_len", 32'(busy_cnt), 32'(HALF));
    check("glitch_busy_end", 32'(busy), 32'd0);
    clear();
    send_frame(8'h81, 1'b0, 40);
    check("brk_busy_held", 32'(busy), 32'd1);
    check("brk_ferr", 32'(fe_cnt), 32'd1);
    check("brk_ferr_time", 32'(fe_cyc - t_start), 32'(LAT));
    check("brk_tvalid", 32'(tv_cnt), 32'd0);
    check("brk_tdata_kept", 32'(m_axis_tdata), 32'h3C);
    tick(4);
    check("brk_busy_end", 32'(busy), 32'd0);
    tick(10);
    clear();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      tick(CPB);
    end
    rx = 1'b1;
    tick(HALF);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tdata", 32'(m_axis_tdata), 32'h00);
    tick(3 * CPB);
    send_frame(8'h12, 1'b1, 0);
    tick(20);
    check("rst_mid_count", 32'(tv_cnt), 32'd1);
    check("rst_mid_data", 32'(got_q[0]), 32'h12);
    check("rst_mid_ferr", 32'(fe_cnt), 32'd0);
    clear();
    acc = 8'h00;
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h10, 1'b1, 0);
    send_frame(8'h80, 1'b1, 0);
    tick(20);
    check("acc_count", 32'(tv_cnt), 32'd3);
    check("acc_result", 32'(acc), 32'h91);
    check("never_both", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
